// File: rtl/aoi222_bist_pkg.sv
// ---------------------------------------------------------------------------
// aoi222_bist_pkg
// Shared definitions for the aoi222 exhaustive BIST sequencer:
//   - bist_state_e : sequencer states (IDLE, APPLY, SAMPLE, FIN)
//   - VEC_LAST     : last stimulus vector of a run
//   - ERR_MAX      : saturation value of the mismatch counter
//   - MISR_POLY    : feedback polynomial of the optional signature register
//   - MISR_SEED    : signature register seed value
//   - aoi222_exp() : golden ZN for a stimulus vector {C2,C1,B2,B1,A2,A1}
// ---------------------------------------------------------------------------
package aoi222_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } bist_state_e;

  localparam logic [5:0]  VEC_LAST  = 6'd63;
  localparam logic [6:0]  ERR_MAX   = 7'd64;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Golden output of the AOI222 cell; bit order is {C2,C1,B2,B1,A2,A1}
  function automatic logic aoi222_exp(input logic [5:0] vec);
    return ~((vec[0] & vec[1]) | (vec[2] & vec[3]) | (vec[4] & vec[5]));
  endfunction

endpackage

// File: rtl/aoi222_bist_misr.sv
// ---------------------------------------------------------------------------
// aoi222_bist_misr
// Single-input serial signature register compressing the CUT response.
// Ports:
//   CLK  in   clock, rising edge
//   RN   in   asynchronous active-low reset (loads the seed)
//   clr  in   synchronous reload of the seed (start of a run)
//   en   in   shift one response bit in this cycle
//   din  in   response bit (CUT ZN)
//   sig  out  current signature
// ---------------------------------------------------------------------------
module aoi222_bist_misr
  import aoi222_bist_pkg::*;
#(
  parameter int SIG_W = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);
  localparam logic [SIG_W-1:0] SEED = SIG_W'(MISR_SEED);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Galois-style shift: the bit falling off the top, mixed with the input
  // bit, decides whether the polynomial is folded back in.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ din) ? POLY : '0);
    end
  end

  // Signature register; reset loads the seed so an idle SIGNATURE is all ones
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/aoi222_bist_ctrl.sv
// ---------------------------------------------------------------------------
// aoi222_bist_ctrl
// Exhaustive BIST sequencer for one aoi222 cell under test. Walks all 64
// input vectors, holds each for SETTLE cycles, samples ZN for one cycle and
// counts mismatches against the golden function.
// Ports:
//   CLK        in     clock, rising edge
//   RN         in     asynchronous active-low reset
//   VDD, VSS   inout  supply pins, no functional use
//   START      in     run request, accepted only in IDLE
//   ABORT      in     synchronous abort, highest priority after RN
//   STIM       out    CUT inputs {C2,C1,B2,B1,A2,A1}
//   CUT_ZN     in     ZN returned from the CUT
//   BUSY       out    high while vectors are being applied/sampled
//   DONE       out    run finished, held until next accepted START or ABORT
//   PASS       out    valid with DONE, 1 when no mismatch was seen
//   ERR_CNT    out    mismatch count, saturates at 64
//   SIGNATURE  out    response signature
// Configuration:
//   AOI222_BIST_MISR_EN  build the signature register; otherwise SIGNATURE
//                        is tied to all ones.
// ---------------------------------------------------------------------------
module aoi222_bist_ctrl
  import aoi222_bist_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int SIG_W  = 16
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             START,
  input  logic             ABORT,
  output logic [5:0]       STIM,
  input  logic             CUT_ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [6:0]       ERR_CNT,
  output logic [SIG_W-1:0] SIGNATURE
);

  // Counter load value: the hold window counts SETTLE-1 down to 0
  localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

  bist_state_e state_q;
  bist_state_e state_d;

  logic [5:0] vec_q;
  logic [5:0] vec_d;
  logic [3:0] wait_q;
  logic [3:0] wait_d;
  logic [6:0] errCnt_q;
  logic [6:0] errCnt_d;
  logic       done_q;
  logic       done_d;
  logic       pass_q;
  logic       pass_d;
  logic       mismatch;

  // State register
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ABORT pre-empts every transition including START
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (START) state_d = APPLY;
        APPLY:   if (wait_q == 4'd0) state_d = SAMPLE;
        SAMPLE:  state_d = (vec_q == VEC_LAST) ? FIN : APPLY;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; STIM is parked at zero outside a run
  always_comb begin
    BUSY = 1'b0;
    STIM = 6'd0;
    case (state_q)
      APPLY, SAMPLE: begin
        BUSY = 1'b1;
        STIM = vec_q;
      end
      default: begin
        BUSY = 1'b0;
        STIM = 6'd0;
      end
    endcase
  end

  assign mismatch = (CUT_ZN != aoi222_exp(vec_q));

  // Datapath next-state: vector index, hold counter, mismatch counter and
  // result flags. An abort only clears the result flags; the counters keep
  // whatever the partial run accumulated.
  always_comb begin
    vec_d    = vec_q;
    wait_d   = wait_q;
    errCnt_d = errCnt_q;
    done_d   = done_q;
    pass_d   = pass_q;
    if (ABORT) begin
      done_d = 1'b0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            vec_d    = 6'd0;
            wait_d   = WAIT_INIT;
            errCnt_d = 7'd0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
          end
        end
        APPLY: begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch && (errCnt_q != ERR_MAX)) begin
            errCnt_d = errCnt_q + 7'd1;
          end
          // At the last vector FIN takes over, so vec never wraps in a run
          if (vec_q != VEC_LAST) begin
            vec_d  = vec_q + 6'd1;
            wait_d = WAIT_INIT;
          end
        end
        FIN: begin
          done_d = 1'b1;
          pass_d = (errCnt_q == 7'd0);
        end
        default: begin
          vec_d = vec_q;
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      vec_q    <= 6'd0;
      wait_q   <= 4'd0;
      errCnt_q <= 7'd0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      wait_q   <= wait_d;
      errCnt_q <= errCnt_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = errCnt_q;

`ifdef AOI222_BIST_MISR_EN
  logic misrClr;
  logic misrEn;

  // Seed on an accepted START, shift once per SAMPLE, freeze on ABORT
  assign misrClr = (state_q == IDLE) && START && !ABORT;
  assign misrEn  = (state_q == SAMPLE) && !ABORT;

  aoi222_bist_misr #(
    .SIG_W (SIG_W)
  ) uMisr (
    .CLK (CLK),
    .RN  (RN),
    .clr (misrClr),
    .en  (misrEn),
    .din (CUT_ZN),
    .sig (SIGNATURE)
  );
`else
  assign SIGNATURE = {SIG_W{1'b1}};
`endif

endmodule

// File: tb/tb_aoi222_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aoi222_bist_ctrl
// Self-checking bench for aoi222_bist_ctrl. A behavioural CUT (good cell,
// stuck-at faults or a per-vector fault mask) answers STIM; expected error
// counts, pass flags and signatures are computed from a whole-run model.
// ---------------------------------------------------------------------------
module tb_aoi222_bist_ctrl;

  logic        clk;
  logic        rn;
  logic        start;
  logic        abort;
  logic [5:0]  stim;
  logic        cutZn;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  errCnt;
  logic [15:0] signature;
  wire         vdd;
  wire         vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  // CUT behaviour: 0 = good cell xor faultMask, 1 = stuck-at-0, 2 = stuck-at-1
  logic [1:0]  zMode;
  logic [63:0] faultMask;

  int checkCount;
  int errorCount;

  aoi222_bist_ctrl #(
    .SETTLE (2),
    .SIG_W  (16)
  ) dut (
    .CLK       (clk),
    .RN        (rn),
    .VDD       (vdd),
    .VSS       (vss),
    .START     (start),
    .ABORT     (abort),
    .STIM      (stim),
    .CUT_ZN    (cutZn),
    .BUSY      (busy),
    .DONE      (done),
    .PASS      (pass),
    .ERR_CNT   (errCnt),
    .SIGNATURE (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden cell: output high only when no input pair is fully set
  function automatic logic refZn(input logic [5:0] v);
    int pairsOn;
    pairsOn = int'(v[0] && v[1]) + int'(v[2] && v[3]) + int'(v[4] && v[5]);
    return (pairsOn == 0);
  endfunction

  // Behavioural CUT as seen by the DUT
  assign cutZn = (zMode == 2'd1) ? 1'b0 :
                 (zMode == 2'd2) ? 1'b1 :
                 (refZn(stim) ^ faultMask[stim]);

  // Model of what the CUT answers for a given vector
  function automatic logic cutModel(input int v);
    logic [5:0] vv;
    vv = 6'(v);
    if (zMode == 2'd1) return 1'b0;
    if (zMode == 2'd2) return 1'b1;
    return refZn(vv) ^ faultMask[v];
  endfunction

  // Expected mismatches over the first nVecs vectors, saturating at 64
  function automatic int refErrors(input int nVecs);
    int n;
    n = 0;
    for (int v = 0; v < nVecs; v++) begin
      if (cutModel(v) != refZn(6'(v))) n++;
    end
    return (n > 64) ? 64 : n;
  endfunction

  // Expected signature after nVecs responses
  function automatic logic [15:0] misrModel(input int nVecs);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int v = 0; v < nVecs; v++) begin
      s = {s[14:0], 1'b0} ^ ((s[15] ^ cutModel(v)) ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  function automatic logic [15:0] expSig(input int nVecs);
`ifdef AOI222_BIST_MISR_EN
    return misrModel(nVecs);
`else
    return (nVecs >= 0) ? 16'hFFFF : 16'hFFFF;
`endif
  endfunction

  task automatic checkOutput(input string tag, input longint unsigned observed,
                             input longint unsigned expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bounded wait until STIM shows a given vector (sampled on negedges)
  task automatic waitStim(input logic [5:0] target);
    int n;
    n = 0;
    while (stim != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stimReach", stim, target);
  endtask

  // One complete run: pulse (or hold) START, follow it to DONE, then check
  // run length, busy length, per-increment fault location and results.
  task automatic applyStimulus(input string tag, input bit holdStart);
    int         cycles;
    int         busyCycles;
    bit         seen;
    logic [5:0] prevStim;
    logic [6:0] prevErr;
    int         expErr;

    expErr     = refErrors(64);
    cycles     = 0;
    busyCycles = 0;
    seen       = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    prevStim = stim;
    prevErr  = errCnt;
    while (!seen && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      if (!holdStart) start = 1'b0;
      if (busy) busyCycles++;
      if (cycles == 1) begin
        checkOutput({tag, " errClr"}, errCnt, 0);
      end else if (errCnt != prevErr) begin
        checkOutput({tag, " errVec"}, cutModel(int'(prevStim)) != refZn(prevStim), 1);
      end
      prevStim = stim;
      prevErr  = errCnt;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput({tag, " doneSeen"}, seen, 1);
    checkOutput({tag, " runCycles"}, cycles, 194);
    checkOutput({tag, " busyCycles"}, busyCycles, 192);
    checkOutput({tag, " errCnt"}, errCnt, expErr);
    checkOutput({tag, " pass"}, pass, (expErr == 0));
    checkOutput({tag, " sig"}, signature, expSig(64));
    @(negedge clk);
    checkOutput({tag, " doneHold"}, done, 1);
    checkOutput({tag, " busyIdle"}, busy, 0);
  endtask

  logic [15:0] goodSig;
  logic [15:0] s0Sig;
  logic [6:0]  frozenErr;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rn         = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    zMode      = 2'd0;
    faultMask  = 64'd0;

    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    checkOutput("rstStim", stim, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstPass", pass, 0);
    checkOutput("rstErr", errCnt, 0);
    checkOutput("rstSig", signature, 16'hFFFF);
    rn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] good cut");
    applyStimulus("good", 1'b0);
    goodSig = signature;

    $display("[TB] stuck-at faults");
    zMode = 2'd1;
    checkOutput("model s0", refErrors(64), 27);
    applyStimulus("stuck0", 1'b0);
    s0Sig = signature;
    zMode = 2'd2;
    checkOutput("model s1", refErrors(64), 37);
    applyStimulus("stuck1", 1'b0);
`ifdef AOI222_BIST_MISR_EN
    checkOutput("sigDiffers", goodSig != s0Sig, 1);
`else
    checkOutput("sigTied", s0Sig, 16'hFFFF);
`endif

    $display("[TB] single fault at vector 3");
    zMode     = 2'd0;
    faultMask = 64'd1 << 3;
    applyStimulus("vec3", 1'b0);

    $display("[TB] random fault masks");
    for (int i = 0; i < 4; i++) begin
      faultMask = {$urandom, $urandom};
      if (i[0]) faultMask = faultMask & {$urandom, $urandom} & {$urandom, $urandom};
      applyStimulus("rand", 1'b0);
    end

    $display("[TB] START held through a run");
    faultMask = {$urandom, $urandom} & {$urandom, $urandom};
    applyStimulus("hold", 1'b1);

    $display("[TB] ABORT at vector 10");
    faultMask = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitStim(6'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortPass", pass, 0);
    checkOutput("abortStim", stim, 0);
    checkOutput("abortErr", errCnt, refErrors(10));
    checkOutput("abortSig", signature, expSig(10));
    repeat (5) @(negedge clk);
    checkOutput("abortErrFrozen", errCnt, refErrors(10));
    checkOutput("abortStayIdle", busy, 0);

    $display("[TB] START with ABORT in IDLE");
    faultMask = 64'd0;
    applyStimulus("preAbort", 1'b0);
    frozenErr = errCnt;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("idleAbortBusy", busy, 0);
    checkOutput("idleAbortDone", done, 0);
    checkOutput("idleAbortPass", pass, 0);
    repeat (3) @(negedge clk);
    checkOutput("idleAbortNoRun", busy, 0);
    checkOutput("idleAbortErr", errCnt, 7'(refErrors(64)));

    $display("[TB] reset mid-run");
    faultMask = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitStim(6'd40);
    #2;
    rn = 1'b0;
    #1;
    checkOutput("midRstStim", stim, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstPass", pass, 0);
    checkOutput("midRstErr", errCnt, 0);
    checkOutput("midRstSig", signature, 16'hFFFF);
    @(negedge clk);
    rn = 1'b1;
    faultMask = 64'd0;
    applyStimulus("afterRst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
